tinywhisper_uart_rx: RTL and testbench
======================================

// Module: tinywhisper_uart_rx
// PURPOSE
//  UART receiver: consumes the serial `rx` line driven by the external transmitter and delivers bytes to the tinywhisper_riscv core.
//  Format is fixed at 8N1, LSB first. A 2-FF synchronizer, a mid-bit sampling FSM and a small show-ahead FIFO buffer the bytes.
//  `intr` feeds the core interrupt logic. The core pops bytes with `rd_en`.
// PARAMETERS
//  CLK_FREQ       12_000_000  system clock frequency in Hz
//  BAUD           115_200     line rate in bit/s
//  CLKS_PER_BIT   CLK_FREQ/BAUD (=104)  cycles per bit; overridable for sim, must be >= 4
//  FIFO_DEPTH     4           receive FIFO entries; power of 2, >= 2
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  reset      in   1  synchronous, active-high reset
//  rx         in   1  asynchronous serial input, idle high
//  rd_en      in   1  pop FIFO head; ignored when rd_valid=0
//  rd_data    out  8  FIFO head byte (show-ahead); 8'h00 when empty
//  rd_valid   out  1  FIFO not empty
//  intr       out  1  level interrupt, equals rd_valid
//  frame_err  out  1  sticky: a stop bit was sampled low
//  overrun    out  1  sticky: a byte was dropped because the FIFO was full
//  clr_err    in   1  clears frame_err and overrun
// BEHAVIOUR
//  - Reset (sync, high) values:
//    - rd_data=0, rd_valid=0, intr=0, frame_err=0, overrun=0.
//    - Synchronizer flops reset to 1. FSM goes to IDLE. FIFO is emptied.
//    - Reset asserted mid-frame abandons the frame; no partial byte is ever pushed.
//  - rx passes through 2 flops (rx_s); all decisions use rx_s. The line-to-FSM delay is 2 cycles.
//  - FSM states and transitions:
//    - IDLE: rx_s==0 -> START, bit counter cleared.
//    - START: at cycle CLKS_PER_BIT/2-1, sample rx_s.
//      - Sample 0 -> DATA, bit index 0.
//      - Sample 1 -> IDLE (glitch rejected, no flag).
//    - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift[idx], LSB first. After idx 7 -> STOP.
//    - STOP: after CLKS_PER_BIT cycles, sample rx_s.
//      - Sample 1: push the byte. If the FIFO is full, drop the byte and set overrun. Then -> IDLE.
//      - Sample 0: discard the byte, set frame_err, -> BREAK.
//    - BREAK: wait for rx_s==1 -> IDLE. A held-low line yields exactly one frame_err.
//  - Push timing: the push happens on the cycle after the stop sample; rd_valid rises the following cycle.
//  - The bit counter saturates/wraps only within [0, CLKS_PER_BIT-1]; its width is $clog2(CLKS_PER_BIT).
//  - FIFO rules:
//    - Show-ahead: rd_data is valid whenever rd_valid=1.
//    - Pop on rd_en & rd_valid.
//    - Push and pop in the same cycle: both happen, count is unchanged. This holds when full too (push accepted, no overrun).
//    - rd_en while empty is a no-op.
//    - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty use an extra count bit.
//  - clr_err: clears both sticky flags. If a set event occurs in the same cycle, the set wins.
// STRUCTURE
//  - Shared package: tinywhisper_uart_pkg.
//    - uart_rx_state_e enum {IDLE, START, DATA, STOP, BREAK}.
//    - UART_DATA_BITS=8 constant.
//    - The same package is reused by uart_tx.
//  - Sub-module: tinywhisper_uart_rx_fifo (sync FIFO; push/pop/full/empty, show-ahead). The FSM and synchronizer live in the top.
// TESTING  (CLKS_PER_BIT=16 for speed unless stated)
//  1. Send 8'hA5 with a good stop bit.
//     -> rd_valid=1 within 2+16*9.5+3 cycles of the start edge; rd_data=8'hA5; intr=1.
//     -> rd_en for 1 cycle -> rd_valid=0.
//  2. Drive rx low for 3 cycles, then high.
//     -> FSM returns to IDLE; rd_valid and frame_err stay 0.
//  3. Send 8'h3C with stop bit 0, hold rx low for 40 bits, then release.
//     -> frame_err=1 exactly once, no byte pushed.
//     -> clr_err -> frame_err=0.
//  4. FIFO_DEPTH=4: send 01,02,03,04,05 without reading.
//     -> overrun=1; pops return 01,02,03,04, then rd_valid=0.
//  5. FIFO full, rd_en held over the stop-bit push cycle of byte 8'h77.
//     -> overrun stays 0; after draining, the last byte read is 8'h77.
//  6. Assert reset at DATA bit 4.
//     -> all outputs 0 next cycle.
//     -> a subsequent full frame 8'hC3 is received correctly.
//  7. Default parameters (CLKS_PER_BIT=104): send 8'hA5 from uart_tx.
//     -> received 8'hA5 at the core interface.

Source files
------------

// File: rtl/tinywhisper_uart_pkg.sv
// Shared UART definitions for the tinywhisper receiver and transmitter.
//   UART_DATA_BITS  : payload bits per frame (8N1 format)
//   uart_rx_state_e : receiver FSM states
package tinywhisper_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_e;

endpackage

// File: rtl/tinywhisper_uart_rx_fifo.sv
// Synchronous show-ahead FIFO that buffers received UART bytes.
// Ports:
//   clk, reset : clock and synchronous active-high reset (control state only)
//   push       : write push_data this cycle (accepted if not full, or if a pop
//                happens in the same cycle)
//   push_data  : byte to store
//   pop        : remove the head entry (ignored when empty)
//   head_data  : current head entry, forced to zero when empty
//   full/empty : occupancy flags
module tinywhisper_uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    // One extra bit so a full FIFO is distinguishable from an empty one.
    logic [PTR_W:0]    count;
    logic              do_pop;
    logic              do_push;

    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));

    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/tinywhisper_uart_rx.sv
// UART receiver (8N1, LSB first) feeding the tinywhisper_riscv core.
// The serial line is synchronised by two flops, framed by a mid-bit sampling
// FSM and buffered in a small show-ahead FIFO.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   rx         : asynchronous serial input, idle high
//   rd_en      : pop the FIFO head (ignored when rd_valid=0)
//   rd_data    : FIFO head byte, 8'h00 when empty
//   rd_valid   : FIFO not empty
//   intr       : level interrupt, mirrors rd_valid
//   frame_err  : sticky, a stop bit was sampled low
//   overrun    : sticky, a byte was dropped because the FIFO was full
//   clr_err    : clears both sticky flags (a coincident set wins)
module tinywhisper_uart_rx
    import tinywhisper_uart_pkg::*;
#(
    parameter int CLK_FREQ     = 12_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx,
    input  logic                      rd_en,
    output logic [UART_DATA_BITS-1:0] rd_data,
    output logic                      rd_valid,
    output logic                      intr,
    output logic                      frame_err,
    output logic                      overrun,
    input  logic                      clr_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

    uart_rx_state_e            state;
    logic [CNT_W-1:0]          bit_cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic                      bit_done;
    logic [UART_DATA_BITS-1:0] shift;

    logic                      rx_p0;
    logic                      rx_s_p1;

    logic                      push_vld_p2;
    logic [UART_DATA_BITS-1:0] push_data_p2;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      pop_req;

    // ---- stage p0/p1: two-flop synchroniser, reset to the idle level ----
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_p0   <= 1'b1;
            rx_s_p1 <= 1'b1;
        end else begin
            rx_p0   <= rx;
            rx_s_p1 <= rx_p0;
        end
    end

    assign bit_done = (bit_cnt == BIT_LAST);

    // ---- stage p2: framing FSM; push request registered after stop sample ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            push_vld_p2 <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            push_vld_p2 <= 1'b0;
            // Clear first so a framing error in the same cycle overrides it.
            if (clr_err) begin
                frame_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (!rx_s_p1) begin
                        state <= START;
                    end
                end
                START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        // A line already back high at mid start bit is a glitch.
                        state   <= rx_s_p1 ? IDLE : DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (rx_s_p1) begin
                            push_vld_p2 <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                BREAK: begin
                    // Stay here until the line idles so a held-low line
                    // reports a single framing error.
                    bit_cnt <= '0;
                    if (rx_s_p1) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // Datapath registers: no reset, qualified by the FSM strobes.
    always_ff @(posedge clk) begin
        if (state == DATA && bit_done) begin
            shift[bit_idx] <= rx_s_p1;
        end
        if (state == STOP && bit_done) begin
            push_data_p2 <= shift;
        end
    end

    assign pop_req = rd_en & ~fifo_empty;

    // ---- stage p3: FIFO write and overrun detection ----
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (push_vld_p2 && fifo_full && !pop_req) begin
            overrun <= 1'b1;
        end else if (clr_err) begin
            overrun <= 1'b0;
        end
    end

    tinywhisper_uart_rx_fifo #(
        .DATA_W     (UART_DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_vld_p2),
        .push_data (push_data_p2),
        .pop       (pop_req),
        .head_data (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rd_valid = ~fifo_empty;
    assign intr     = ~fifo_empty;

endmodule

// File: tb/tb_tinywhisper_uart_rx.sv
module tb_tinywhisper_uart_rx;

    localparam int CPB     = 16;
    localparam int DEF_CPB = 12_000_000 / 115_200;
    localparam int DEPTH   = 4;
    localparam int LAT_MAX = 2 + (CPB * 19) / 2 + 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx, rd_en, clr_err;
    logic [7:0] rd_data;
    logic       rd_valid, intr, frame_err, overrun;

    logic       rx_d, rd_en_d, clr_err_d;
    logic [7:0] rd_data_d;
    logic       rd_valid_d, intr_d, frame_err_d, overrun_d;

    int         checks = 0;
    int         errors = 0;
    int         lat    = -1;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    tinywhisper_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .intr(intr), .frame_err(frame_err),
        .overrun(overrun), .clr_err(clr_err)
    );

    tinywhisper_uart_rx dut_d (
        .clk(clk), .reset(reset), .rx(rx_d), .rd_en(rd_en_d), .rd_data(rd_data_d),
        .rd_valid(rd_valid_d), .intr(intr_d), .frame_err(frame_err_d),
        .overrun(overrun_d), .clr_err(clr_err_d)
    );

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_d = v;
        else     rx   = v;
    endtask

    // Transmit one 8N1 frame; the line returns high after the stop bit.
    task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop_v);
        int cpb;
        cpb = sel ? DEF_CPB : CPB;
        @(posedge clk); #1 drive(sel, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (cpb) @(posedge clk);
            #1 drive(sel, d[i]);
        end
        repeat (cpb) @(posedge clk);
        #1 drive(sel, stop_v);
        repeat (cpb) @(posedge clk);
        #1 drive(sel, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rd();
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        rx_d = 1'b1; rd_en_d = 1'b0; clr_err_d = 1'b0;
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({rd_data, rd_valid, intr, frame_err, overrun} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h v=%b i=%b fe=%b ov=%b required all 0",
                     rd_data, rd_valid, intr, frame_err, overrun);
        end
        checks++;
        if ({rd_data_d, rd_valid_d, intr_d, frame_err_d, overrun_d} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs_default: got data=%h v=%b required all 0",
                     rd_data_d, rd_valid_d);
        end
    endtask

    task automatic test_single_byte();
        fork
            send_frame(1'b0, 8'hA5, 1'b1);
            begin
                @(posedge clk); #1;
                lat = -1;
                for (int k = 1; k <= 200; k++) begin
                    @(negedge clk);
                    if (rd_valid) begin
                        lat = k - 1;
                        break;
                    end
                end
            end
        join
        checks++;
        if (lat < 0 || lat > LAT_MAX) begin
            errors++;
            $display("FAIL a5_latency: got %0d cycles required 1..%0d", lat, LAT_MAX);
        end
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || intr !== 1'b1) begin
            errors++;
            $display("FAIL a5_data: got v=%b d=%h i=%b required v=1 d=a5 i=1",
                     rd_valid, rd_data, intr);
        end
        pulse_rd();
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || intr !== 1'b0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL a5_pop: got v=%b i=%b d=%h required 0 0 00", rd_valid, intr, rd_data);
        end
        if (lat < 2) lat = LAT_MAX - 1;
    endtask

    task automatic test_glitch();
        @(posedge clk); #1 rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(3 * CPB);
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL glitch: got v=%b fe=%b required 0 0", rd_valid, frame_err);
        end
    endtask

    task automatic test_frame_error();
        logic [7:0] d;
        d = 8'h3C;
        @(posedge clk); #1 rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rx = d[i];
        end
        repeat (CPB) @(posedge clk);
        #1 rx = 1'b0;
        idle(2 * CPB);
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_set: got fe=%b v=%b required 1 0", frame_err, rd_valid);
        end
        pulse_clr();
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_clear: got %b required 0", frame_err);
        end
        idle(38 * CPB);
        rx = 1'b1;
        idle(2 * CPB);
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_once: got fe=%b v=%b required 0 0", frame_err, rd_valid);
        end
    endtask

    task automatic test_overrun();
        for (int b = 1; b <= 4; b++) begin
            send_frame(1'b0, 8'(b), 1'b1);
            idle(4);
        end
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0 || rd_data !== 8'h01) begin
            errors++;
            $display("FAIL fifo_fill: got ov=%b d=%h required 0 01", overrun, rd_data);
        end
        send_frame(1'b0, 8'h05, 1'b1);
        idle(4);
        @(negedge clk);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b required 1", overrun);
        end
        for (int b = 1; b <= 4; b++) begin
            @(negedge clk);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(b)) begin
                errors++;
                $display("FAIL overrun_drain: got v=%b d=%h required 1 %h", rd_valid, rd_data, 8'(b));
            end
            pulse_rd();
        end
        pulse_rd();
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL overrun_empty: got v=%b d=%h required 0 00", rd_valid, rd_data);
        end
        pulse_clr();
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b required 0", overrun);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] d;
        q.delete();
        for (int b = 0; b < DEPTH; b++) begin
            d = 8'($urandom);
            send_frame(1'b0, d, 1'b1);
            q.push_back(d);
            idle(4);
        end
        fork
            send_frame(1'b0, 8'h77, 1'b1);
            begin
                @(posedge clk); #1;
                repeat (lat - 1) @(posedge clk);
                #1 rd_en = 1'b1;
                @(posedge clk); #1 rd_en = 1'b0;
            end
        join
        void'(q.pop_front());
        q.push_back(8'h77);
        idle(4);
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop_overrun: got %b required 0", overrun);
        end
        while (q.size() > 0) begin
            @(negedge clk);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== q[0]) begin
                errors++;
                $display("FAIL full_push_pop_drain: got v=%b d=%h required 1 %h", rd_valid, rd_data, q[0]);
            end
            void'(q.pop_front());
            pulse_rd();
        end
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop_empty: got %b required 0", rd_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        send_frame(1'b0, 8'h5A, 1'b1);
        idle(4);
        send_frame(1'b0, 8'h99, 1'b0);
        idle(4);
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || frame_err !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: got v=%b fe=%b required 1 1", rd_valid, frame_err);
        end
        d = 8'($urandom);
        @(posedge clk); #1 rx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rx = d[i];
        end
        idle(CPB / 2);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        checks++;
        if ({rd_data, rd_valid, intr, frame_err, overrun} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_frame: got d=%h v=%b i=%b fe=%b ov=%b required all 0",
                     rd_data, rd_valid, intr, frame_err, overrun);
        end
        idle(12 * CPB);
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_partial: got v=%b fe=%b required 0 0", rd_valid, frame_err);
        end
        send_frame(1'b0, 8'hC3, 1'b1);
        idle(4);
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hC3 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_c3: got v=%b d=%h fe=%b required 1 c3 0", rd_valid, rd_data, frame_err);
        end
        pulse_rd();
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       stop_v;
        logic       exp_fe, exp_ov;
        int         npop;
        q.delete();
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        for (int f = 0; f < 16; f++) begin
            d      = 8'($urandom);
            stop_v = ($urandom_range(0, 4) != 0);
            send_frame(1'b0, d, stop_v);
            idle(4);
            if (!stop_v)                exp_fe = 1'b1;
            else if (q.size() == DEPTH) exp_ov = 1'b1;
            else                        q.push_back(d);
            @(negedge clk);
            checks++;
            if (frame_err !== exp_fe || overrun !== exp_ov || rd_valid !== (q.size() > 0) ||
                rd_data !== ((q.size() > 0) ? q[0] : 8'h00)) begin
                errors++;
                $display("FAIL random_frame %0d: got fe=%b ov=%b v=%b d=%h required fe=%b ov=%b v=%b d=%h",
                         f, frame_err, overrun, rd_valid, rd_data, exp_fe, exp_ov, q.size() > 0,
                         (q.size() > 0) ? q[0] : 8'h00);
            end
            npop = $urandom_range(0, q.size());
            for (int p = 0; p < npop; p++) begin
                @(negedge clk);
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== q[0]) begin
                    errors++;
                    $display("FAIL random_pop: got v=%b d=%h required 1 %h", rd_valid, rd_data, q[0]);
                end
                void'(q.pop_front());
                pulse_rd();
            end
            if ($urandom_range(0, 3) == 0) begin
                pulse_clr();
                exp_fe = 1'b0;
                exp_ov = 1'b0;
            end
        end
        while (q.size() > 0) begin
            void'(q.pop_front());
            pulse_rd();
        end
        pulse_clr();
    endtask

    task automatic test_default_baud();
        send_frame(1'b1, 8'hA5, 1'b1);
        idle(8);
        @(negedge clk);
        checks++;
        if (rd_valid_d !== 1'b1 || rd_data_d !== 8'hA5 || intr_d !== 1'b1 || frame_err_d !== 1'b0) begin
            errors++;
            $display("FAIL default_baud_a5: got v=%b d=%h i=%b fe=%b required 1 a5 1 0",
                     rd_valid_d, rd_data_d, intr_d, frame_err_d);
        end
        @(posedge clk); #1 rd_en_d = 1'b1;
        @(posedge clk); #1 rd_en_d = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_valid_d !== 1'b0) begin
            errors++;
            $display("FAIL default_baud_pop: got %b required 0", rd_valid_d);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_full_push_pop();
        test_reset_mid_frame();
        test_random();
        test_default_baud();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
